// File: rtl/f_pc_unit_pkg.sv
// Shared fetch-stage constants: exception-code width/values, default PCs and the
// next-PC source select used by f_pc_unit.
package f_pc_unit_pkg;

    localparam int EXCCODE_SIZE = 5;

    localparam logic [EXCCODE_SIZE-1:0] EXC_NONE = 5'd0;
    localparam logic [EXCCODE_SIZE-1:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_RESET         = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER       = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_ERET,
        SEL_HOLD,
        SEL_HANDLER
    } pc_sel_e;

    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             instr;
        logic [EXCCODE_SIZE-1:0] exc_code;
        logic                    bd;
    } f_bundle_t;

    // Window compare widened to 33 bits so base+bytes cannot wrap past 2^32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] bytes);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, bytes};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/f_addr_check.sv
// Combinational word-alignment and window check; returns AdEL for a bad address.
// Shared by instruction fetch and D-stage data loads.
module f_addr_check
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] BYTES = IM_BYTES_DEFAULT
) (
    input  logic [31:0]             addr,
    output logic [EXCCODE_SIZE-1:0] exc_code
);

    always_comb begin
        exc_code = EXC_NONE;
        if ((addr[1:0] != 2'b00) || !in_window(addr, BASE, BYTES)) begin
            exc_code = EXC_ADEL;
        end
    end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch PC register, next-PC selection and F-stage bundle for the P7 MIPS core.
// Optional FETCH_STAT_EN adds fetch_cnt / redirect_cnt statistics outputs.
module f_pc_unit
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET,
    parameter logic [31:0] HANDLER_PC = PC_HANDLER,
    parameter logic [31:0] IM_BASE    = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_BYTES   = IM_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    stall,
    input  logic                    D_eret,
    input  logic [31:0]             epc,
    input  logic                    D_jump,
    input  logic                    D_taken,
    input  logic [31:0]             D_target,
    output logic [31:0]             i_inst_addr,
    input  logic [31:0]             i_inst_rdata,
    output logic [31:0]             F_PC,
    output logic [31:0]             F_instr,
    output logic [EXCCODE_SIZE-1:0] F_ExcCode,
    output logic                    F_BD
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]             fetch_cnt,
    output logic [31:0]             redirect_cnt
`endif
);

    logic [31:0]             pc;
    logic [31:0]             next_pc;
    pc_sel_e                 sel;
    logic [EXCCODE_SIZE-1:0] fetch_exc;
    f_bundle_t               f_out;

    // Same priority as the F/D register: req beats stall; reset is handled in the register.
    always_comb begin
        sel = SEL_SEQ;
        if (req) begin
            sel = SEL_HANDLER;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (D_eret) begin
            sel = SEL_ERET;
        end else if (D_taken) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        next_pc = pc + 32'd4;
        case (sel)
            SEL_HANDLER: next_pc = HANDLER_PC;
            SEL_HOLD:    next_pc = pc;
            SEL_ERET:    next_pc = epc;
            SEL_BRANCH:  next_pc = D_target;
            default:     next_pc = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    f_addr_check #(
        .BASE  (IM_BASE),
        .BYTES (IM_BYTES)
    ) u_fetch_check (
        .addr     (pc),
        .exc_code (fetch_exc)
    );

    // eret has no delay slot: the slot instruction is turned into a clean bubble.
    always_comb begin
        f_out.pc       = pc;
        f_out.bd       = D_jump & ~D_eret;
        f_out.exc_code = fetch_exc;
        f_out.instr    = (fetch_exc == EXC_NONE) ? i_inst_rdata : 32'd0;
        if (D_eret) begin
            f_out.instr    = 32'd0;
            f_out.exc_code = EXC_NONE;
        end
    end

    assign i_inst_addr = pc;
    assign F_PC        = f_out.pc;
    assign F_instr     = f_out.instr;
    assign F_ExcCode   = f_out.exc_code;
    assign F_BD        = f_out.bd;

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt    <= 32'd0;
            redirect_cnt <= 32'd0;
        end else begin
            if ((sel == SEL_SEQ) || (sel == SEL_BRANCH)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((sel == SEL_HANDLER) || (sel == SEL_ERET) || (sel == SEL_BRANCH)) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
